grid_editor: RTL and testbench

Button-driven cell editor that writes into the Game of Life grid from the user side, while `vga` reads it from the display side. It debounces the `left`/`right` push-buttons and runs a RUN/EDIT mode machine. In EDIT it moves a cursor over the grid and issues single-cell toggle writes to `game_of_life` through a valid/ready handshake. It also outputs the cursor position and a pause flag, so the simulation freezes and `vga` can highlight the cursor cell.

---
 rtl/grid_editor_if.sv | 27 ++
 rtl/grid_editor.sv | 179 +++++++++++++++++
 tb/tb_grid_editor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_editor_if.sv
// Toggle-write channel from grid_editor into the Game of Life grid (valid/ready handshake).
interface grid_editor_if #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned HEIGHT = 15
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [$clog2(WIDTH)-1:0]  wr_x;
  logic [$clog2(HEIGHT)-1:0] wr_y;
  logic                      wr_value;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_value,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_value,
    output wr_ready
  );
endinterface

// File: rtl/grid_editor.sv
// Button-driven cursor editor for the Game of Life grid: debounced left/right, RUN/EDIT/WRITE FSM.
// Optional cursor blink is enabled by defining GRID_EDITOR_BLINK_EN.
module grid_editor #(
  parameter int unsigned WIDTH           = 20,
  parameter int unsigned HEIGHT          = 15,
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned BLINK_CYCLES    = 10000000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             left,
  input  logic                             right,
  input  logic [HEIGHT-1:0][WIDTH-1:0]     grid,
  grid_editor_if.master                    wr,
  output logic [$clog2(WIDTH)-1:0]         cursor_x,
  output logic [$clog2(HEIGHT)-1:0]        cursor_y,
  output logic                             cursor_visible,
  output logic                             pause
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [XW-1:0] XLast  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast  = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] DbLast = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StEdit, StWrite} state_e;

  // Bit 0 is left, bit 1 is right throughout.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, db_q, db_prev_q, taint_q;
  logic [CW-1:0] db_cnt_q [2];
  logic [1:0]    rise, fall, other, single;
  logic          chord;

  assign raw = {right, left};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise   = db_q & ~db_prev_q;
  assign fall   = ~db_q & db_prev_q;
  assign other  = {db_q[0], db_q[1]};
  assign chord  = (&db_q) & ~(&db_prev_q);
  assign single = fall & ~taint_q;

  // A press is tainted if the other button was held at any point while it was down.
  always_ff @(posedge clk) begin
    if (reset) begin
      taint_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rise[i]) begin
          taint_q[i] <= other[i];
        end else if (db_q[i] && other[i]) begin
          taint_q[i] <= 1'b1;
        end
      end
    end
  end

  state_e        state_q;
  logic [XW-1:0] cx_q, wx_q;
  logic [YW-1:0] cy_q, wy_q;
  logic          wv_q, wval_q, pause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cx_q    <= '0;
      cy_q    <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      wv_q    <= 1'b0;
      wval_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (chord) begin
            state_q <= StEdit;
            pause_q <= 1'b1;
          end
        end
        StEdit: begin
          if (chord) begin
            state_q <= StRun;
            pause_q <= 1'b0;
          end else if (single[0]) begin
            if (cx_q == XLast) begin
              cx_q <= '0;
              cy_q <= (cy_q == YLast) ? '0 : cy_q + 1'b1;
            end else begin
              cx_q <= cx_q + 1'b1;
            end
          end else if (single[1]) begin
            wx_q    <= cx_q;
            wy_q    <= cy_q;
            wval_q  <= ~grid[cy_q][cx_q];
            wv_q    <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          // Button events are dropped here, chords included.
          if (wv_q && wr.wr_ready) begin
            wv_q    <= 1'b0;
            state_q <= StEdit;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign wr.wr_valid = wv_q;
  assign wr.wr_x     = wx_q;
  assign wr.wr_y     = wy_q;
  assign wr.wr_value = wval_q;
  assign cursor_x    = cx_q;
  assign cursor_y    = cy_q;
  assign pause       = pause_q;

`ifdef GRID_EDITOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic          blink_restart;

  // Restart visible so the cursor shows immediately after entering EDIT or moving.
  assign blink_restart = ((state_q == StRun) && chord) || ((state_q == StEdit) && single[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_restart) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign cursor_visible = pause_q & phase_q;
`else
  logic unused_blink_cycles;
  assign unused_blink_cycles = ^BLINK_CYCLES;
  assign cursor_visible      = pause_q;
`endif

endmodule

// File: tb/tb_grid_editor.sv
// Self-checking bench for grid_editor on a 4x3 grid with short debounce/blink periods.
module tb_grid_editor;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                left;
  logic                right;
  logic [H-1:0][W-1:0] grid;
  logic [XW-1:0]       cursor_x;
  logic [YW-1:0]       cursor_y;
  logic                cursor_visible;
  logic                pause;

  grid_editor_if #(.WIDTH(W), .HEIGHT(H)) wr_if ();

  grid_editor #(
    .WIDTH          (W),
    .HEIGHT         (H),
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .left          (left),
    .right         (right),
    .grid          (grid),
    .wr            (wr_if),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .cursor_visible(cursor_visible),
    .pause         (pause)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] wr_exp_q [$];
  logic [3:0] cur_exp_q [$];
  logic [3:0] cur_last = '0;
  logic [4:0] wr_e;
  logic [3:0] cur_e;
  int         ex = 0;
  int         ey = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_left();
    left = 1'b1;
    tick(10);
    left = 1'b0;
    tick(10);
  endtask

  task automatic chord_press();
    left  = 1'b1;
    right = 1'b1;
    tick(10);
    left  = 1'b0;
    right = 1'b0;
    tick(12);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!wr_if.wr_valid && k < 40) begin
      tick(1);
      k++;
    end
    check(tag, 32'(wr_if.wr_valid), 32'd1);
  endtask

  task automatic step_model();
    if (ex == W - 1) begin
      ex = 0;
      ey = (ey == H - 1) ? 0 : ey + 1;
    end else begin
      ex = ex + 1;
    end
    cur_exp_q.push_back({2'(ex), 2'(ey)});
  endtask

  // Scoreboard side: completed handshakes and cursor changes consume expected entries.
  always @(negedge clk) begin
    if (!reset && wr_if.wr_valid && wr_if.wr_ready) begin
      if (wr_exp_q.size() == 0) begin
        check("write_unexpected", 32'd1, 32'd0);
      end else begin
        wr_e = wr_exp_q.pop_front();
        check("write_payload", 32'({wr_if.wr_x, wr_if.wr_y, wr_if.wr_value}), 32'(wr_e));
      end
    end
    if ({cursor_x, cursor_y} != cur_last) begin
      if (cur_exp_q.size() == 0) begin
        check("cursor_unexpected", 32'({cursor_x, cursor_y}), 32'(cur_last));
      end else begin
        cur_e = cur_exp_q.pop_front();
        check("cursor_step", 32'({cursor_x, cursor_y}), 32'(cur_e));
      end
      cur_last = {cursor_x, cursor_y};
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    left  = 1'b0;
    right = 1'b0;
    grid  = '0;
    grid[0] = 4'b1010;
    grid[1] = 4'b1001;
    grid[2] = 4'b0110;
    wr_if.wr_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_wr_valid", 32'(wr_if.wr_valid), 32'd0);
    check("rst_wr_x", 32'(wr_if.wr_x), 32'd0);
    check("rst_wr_y", 32'(wr_if.wr_y), 32'd0);
    check("rst_wr_value", 32'(wr_if.wr_value), 32'd0);
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_visible", 32'(cursor_visible), 32'd0);
    check("rst_cursor", 32'({cursor_x, cursor_y}), 32'd0);

    // Bounce: level never stable long enough to be accepted.
    for (int i = 0; i < 20; i++) begin
      left = ((i / 2) % 2) == 0;
      tick(1);
    end
    left = 1'b0;
    tick(12);
    check("bounce_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    check("bounce_pause", 32'(pause), 32'd0);

    chord_press();
    check("enter_pause", 32'(pause), 32'd1);
`ifndef GRID_EDITOR_BLINK_EN
    check("enter_visible", 32'(cursor_visible), 32'd1);
`endif

    for (int p = 1; p <= 12; p++) begin
      step_model();
      press_left();
      if (p == 3) check("cursor_after3", 32'({cursor_x, cursor_y}), 32'({2'd3, 2'd0}));
      if (p == 4) check("cursor_after4", 32'({cursor_x, cursor_y}), 32'({2'd0, 2'd1}));
    end
    check("cursor_wrap", 32'({cursor_x, cursor_y}), 32'd0);

    for (int p = 0; p < 6; p++) begin
      step_model();
      press_left();
    end
    check("cursor_at_2_1", 32'({cursor_x, cursor_y}), 32'({2'd2, 2'd1}));

    // Toggle write with ready held low for 5 cycles.
    wr_exp_q.push_back({2'd2, 2'd1, 1'b1});
    right = 1'b1;
    tick(10);
    right = 1'b0;
    wait_valid("toggle_valid_rise");
    for (int i = 0; i < 6; i++) begin
      check("toggle_hold_valid", 32'(wr_if.wr_valid), 32'd1);
      check("toggle_hold_payload", 32'({wr_if.wr_x, wr_if.wr_y, wr_if.wr_value}),
            32'({2'd2, 2'd1, 1'b1}));
      if (i == 5) wr_if.wr_ready = 1'b1;
      tick(1);
    end
    wr_if.wr_ready = 1'b0;
    check("toggle_valid_drop", 32'(wr_if.wr_valid), 32'd0);
    check("toggle_back_edit", 32'(pause), 32'd1);

    // Chord exclusivity: left held while right taps, expect a single exit to RUN.
    left = 1'b1;
    tick(10);
    right = 1'b1;
    tick(10);
    right = 1'b0;
    tick(10);
    left = 1'b0;
    tick(12);
    check("excl_pause", 32'(pause), 32'd0);
    check("excl_wr_valid", 32'(wr_if.wr_valid), 32'd0);
    check("excl_cursor", 32'({cursor_x, cursor_y}), 32'({2'd2, 2'd1}));

    // Re-enter EDIT and watch the blink phase from the first paused cycle.
    left  = 1'b1;
    right = 1'b1;
    for (int k = 0; k < 40 && !pause; k++) tick(1);
    check("blink_pause_on", 32'(pause), 32'd1);
    for (int i = 0; i < 24; i++) begin
`ifdef GRID_EDITOR_BLINK_EN
      check("blink_phase", 32'(cursor_visible), 32'(((i / 8) % 2) == 0));
`else
      check("blink_const", 32'(cursor_visible), 32'd1);
`endif
      tick(1);
    end
    left  = 1'b0;
    right = 1'b0;
    tick(12);
    check("blink_still_edit", 32'(pause), 32'd1);

    // Write with ready already high: completes on the first valid cycle.
    grid[1][2] = 1'b1;
    wr_exp_q.push_back({2'd2, 2'd1, 1'b0});
    wr_if.wr_ready = 1'b1;
    right = 1'b1;
    tick(10);
    right = 1'b0;
    wait_valid("fast_valid_rise");
    tick(1);
    check("fast_valid_drop", 32'(wr_if.wr_valid), 32'd0);
    wr_if.wr_ready = 1'b0;

    // Reset while a write is pending.
    right = 1'b1;
    tick(10);
    right = 1'b0;
    wait_valid("rstw_valid_rise");
    cur_exp_q.push_back(4'd0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rstw_wr_valid", 32'(wr_if.wr_valid), 32'd0);
    check("rstw_pause", 32'(pause), 32'd0);
    check("rstw_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    check("rstw_visible", 32'(cursor_visible), 32'd0);
    check("rstw_wr_x", 32'(wr_if.wr_x), 32'd0);
    tick(5);
    check("rstw_stays_run", 32'(pause), 32'd0);
    check("rstw_no_valid", 32'(wr_if.wr_valid), 32'd0);

    check("wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);
    check("cursor_queue_empty", 32'(cur_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
